reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the ID stage: 32 x 32-bit MIPS GPRs.
- Consumes the read enables/addresses produced by the ID register-address decoder and the write-back port from the WB stage.
- Returns operand data with same-cycle write-through bypass.
- Contains a load-pending scoreboard that raises a load-use stall request to the pipeline controller.

Parameters:
- DATA_WIDTH, 32, GPR width in bits
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- read_en_1  input  1  read port 1 enable
- read_addr_1  input  ADDR_WIDTH  read port 1 address
- read_data_1  output  DATA_WIDTH  read port 1 data (combinational)
- read_en_2  input  1  read port 2 enable
- read_addr_2  input  ADDR_WIDTH  read port 2 address
- read_data_2  output  DATA_WIDTH  read port 2 data (combinational)
- write_en  input  1  WB write enable
- write_addr  input  ADDR_WIDTH  WB destination
- write_data  input  DATA_WIDTH  WB data
- busy_set_en  input  1  ID issuing a load that will write busy_set_addr
- busy_set_addr  input  ADDR_WIDTH  destination of the issued load
- flush  input  1  pipeline flush; clears scoreboard
- load_stall  output  1  load-use hazard: an enabled read hits a busy register
- debug_addr  input  ADDR_WIDTH  debug read address (REGFILE_DEBUG_EN only)
- debug_data  output  DATA_WIDTH  debug read data (REGFILE_DEBUG_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset (rst_n=0 at a rising edge): all 32 GPRs are set to 0 and all busy bits are cleared.
  - Reset overrides a write, busy_set_en and flush in the same cycle.
  - The outputs are combinational, so after reset read_data_* = 0 and load_stall = 0.
- Register $0:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
  - busy_set_en with address 0 is ignored; busy[0] is never set.
- Write: on a rising edge with write_en=1 and write_addr!=0, gpr[write_addr] <= write_data.
- Read port n (n = 1 or 2), evaluated in priority order:
  1. read_en_n=0 -> data 0.
  2. addr=0 -> 0.
  3. write_en=1 and write_addr==addr -> write_data (bypass; zero-latency write-to-read).
  4. Otherwise -> gpr[addr].
- Both read ports may read the same address; each applies the bypass independently.
- Scoreboard: 32 busy bits, updated each rising edge.
  - Clear: write_en=1 clears busy[write_addr].
  - Set: busy_set_en=1 sets busy[busy_set_addr]. The set is applied after the clear, so when both target the same address in one cycle the set wins (the newer load is outstanding).
  - flush=1 clears all busy bits; a busy_set_en in the same cycle is still applied afterwards (the issuing instruction survives the flush).
- load_stall is combinational and high when either condition holds:
  - read_en_1 and busy[read_addr_1] and not (write_en and write_addr==read_addr_1)
  - the same condition for port 2.
- The WB write in the current cycle resolves the hazard through the bypass, so no stall is raised for it.
- read_addr=0 never stalls.
- Read ports have no side effects on state; only the write and busy_set ports mutate state.

Optional Feature:
- REGFILE_DEBUG_EN defined:
  - Ports debug_addr and debug_data exist.
  - debug_data = gpr[debug_addr] with the same bypass rule as the read ports, no enable gating, and address 0 returning 0.
- REGFILE_DEBUG_EN undefined:
  - Ports debug_addr and debug_data are absent.
  - No extra logic is generated.

Test Plan:
- Reset then read: rst_n=0 for one edge, then read_en_1=1, addr=5 -> read_data_1=0 and load_stall=0.
- Write then read: write $7=0xDEADBEEF, next cycle read_en_2=1, addr=7 -> read_data_2=0xDEADBEEF; read with read_en_2=0 -> 0.
- Bypass: $3 holds 0x11; in the same cycle write_en=1, addr=3, data=0x22 and read_addr_1=3 -> read_data_1=0x22; the next cycle also reads 0x22.
- $0 protection: write addr 0, data 0xFFFFFFFF; busy_set addr 0 -> reads of $0 return 0 and load_stall stays 0.
- Scoreboard:
  - busy_set addr 9, then next cycle read_en_1=1, addr 9 -> load_stall=1.
  - WB write to $9 with data 0x55 -> load_stall=0 and read_data_1=0x55.
  - The following cycle busy[9]=0.
- Set/clear collision and flush:
  - WB writes $4 while busy_set addr 4 -> busy[4] remains 1.
  - flush=1 with busy_set addr 6 -> only busy[6] is set afterwards.
  - rst_n=0 with busy bits set -> all cleared.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit MIPS GPR file with write-through bypass and a load-use scoreboard.
// Define REGFILE_DEBUG_EN to add the bypassed debug read port (debug_addr/debug_data).
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  busy_set_en,
  input  logic [ADDR_WIDTH-1:0] busy_set_addr,
  input  logic                  flush,
  output logic                  load_stall
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
`endif
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gpr_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  stall_1;
  logic                  stall_2;

  // $0 is held at zero by reset and never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (write_en && write_addr != '0) begin
      gpr_q[write_addr] <= write_data;
    end
  end

  // Flush, then WB clear, then new load set: the newest load always stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end
    if (write_en) begin
      busy_d[write_addr] = 1'b0;
    end
    if (busy_set_en && busy_set_addr != '0) begin
      busy_d[busy_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic en,
                                                      input logic [ADDR_WIDTH-1:0] addr);
    if (!en || addr == '0) begin
      return '0;
    end else if (write_en && write_addr == addr) begin
      return write_data;
    end else begin
      return gpr_q[addr];
    end
  endfunction

  always_comb begin
    read_data_1 = read_port(read_en_1, read_addr_1);
    read_data_2 = read_port(read_en_2, read_addr_2);
  end

  // A same-cycle WB write to the busy register is forwarded, so it does not stall.
  assign stall_1    = read_en_1 && busy_q[read_addr_1] && !(write_en && write_addr == read_addr_1);
  assign stall_2    = read_en_2 && busy_q[read_addr_2] && !(write_en && write_addr == read_addr_2);
  assign load_stall = stall_1 || stall_2;

`ifdef REGFILE_DEBUG_EN
  always_comb begin
    debug_data = read_port(1'b1, debug_addr);
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_en_1, read_en_2;
  logic [4:0]  read_addr_1, read_addr_2;
  logic [31:0] read_data_1, read_data_2;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        busy_set_en;
  logic [4:0]  busy_set_addr;
  logic        flush;
  logic        load_stall;
`ifdef REGFILE_DEBUG_EN
  logic [4:0]  debug_addr;
  logic [31:0] debug_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: architectural register values and outstanding-load flags.
  logic [31:0] m_gpr [32];
  bit          m_busy [32];

  reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1), .read_data_1(read_data_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2), .read_data_2(read_data_2),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .flush(flush),
    .load_stall(load_stall)
`ifdef REGFILE_DEBUG_EN
    , .debug_addr(debug_addr), .debug_data(debug_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] addr);
    if (!en) return 32'h0;
    if (addr == 5'd0) return 32'h0;
    if (write_en && write_addr == addr) return write_data;
    return m_gpr[addr];
  endfunction

  function automatic logic m_stall();
    logic s1, s2;
    s1 = read_en_1 && m_busy[read_addr_1] && !(write_en && write_addr == read_addr_1);
    s2 = read_en_2 && m_busy[read_addr_2] && !(write_en && write_addr == read_addr_2);
    return s1 || s2;
  endfunction

  task automatic m_commit();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_gpr[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (write_en && write_addr != 5'd0) m_gpr[write_addr] = write_data;
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      if (write_en) m_busy[write_addr] = 1'b0;
      if (busy_set_en && busy_set_addr != 5'd0) m_busy[busy_set_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1;
    read_en_1 = 1'b0; read_addr_1 = 5'd0;
    read_en_2 = 1'b0; read_addr_2 = 5'd0;
    write_en = 1'b0; write_addr = 5'd0; write_data = 32'h0;
    busy_set_en = 1'b0; busy_set_addr = 5'd0;
    flush = 1'b0;
`ifdef REGFILE_DEBUG_EN
    debug_addr = 5'd0;
`endif
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 5'd5;
    #1;
    vectors++;
    if (read_data_1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rd1 got=%h exp=%h", read_data_1, 32'h0);
    end
    vectors++;
    if (load_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall got=%b exp=0", load_stall);
    end
    $display("test_reset: rd1=%h stall=%b", read_data_1, load_stall);
    tick();
  endtask

  task automatic test_write_read();
    idle();
    write_en = 1'b1; write_addr = 5'd7; write_data = 32'hDEADBEEF;
    tick();
    idle();
    read_en_2 = 1'b1; read_addr_2 = 5'd7;
    #1;
    vectors++;
    if (read_data_2 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_rd2 got=%h exp=%h", read_data_2, 32'hDEADBEEF);
    end
    read_en_2 = 1'b0;
    #1;
    vectors++;
    if (read_data_2 !== 32'h0) begin
      miscompares++;
      $display("FAIL wr_rd2_disabled got=%h exp=%h", read_data_2, 32'h0);
    end
    $display("test_write_read: $7 written, disabled read=%h", read_data_2);
    tick();
  endtask

  task automatic test_bypass();
    idle();
    write_en = 1'b1; write_addr = 5'd3; write_data = 32'h11;
    tick();
    write_data = 32'h22;
    read_en_1 = 1'b1; read_addr_1 = 5'd3;
    #1;
    vectors++;
    if (read_data_1 !== 32'h22) begin
      miscompares++;
      $display("FAIL bypass_same_cycle got=%h exp=%h", read_data_1, 32'h22);
    end
    tick();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 5'd3;
    #1;
    vectors++;
    if (read_data_1 !== 32'h22) begin
      miscompares++;
      $display("FAIL bypass_next_cycle got=%h exp=%h", read_data_1, 32'h22);
    end
    $display("test_bypass: $3 next-cycle=%h", read_data_1);
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    write_en = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF;
    busy_set_en = 1'b1; busy_set_addr = 5'd0;
    read_en_1 = 1'b1; read_addr_1 = 5'd0;
    #1;
    vectors++;
    if (read_data_1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_no_bypass got=%h exp=%h", read_data_1, 32'h0);
    end
    tick();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 5'd0;
    read_en_2 = 1'b1; read_addr_2 = 5'd0;
    #1;
    vectors++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_read got=%h/%h exp=0/0", read_data_1, read_data_2);
    end
    vectors++;
    if (load_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_stall got=%b exp=0", load_stall);
    end
    $display("test_zero_reg: $0 reads %h/%h stall=%b", read_data_1, read_data_2, load_stall);
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    tick();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 5'd9;
    #1;
    vectors++;
    if (load_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_stall_set got=%b exp=1", load_stall);
    end
    write_en = 1'b1; write_addr = 5'd9; write_data = 32'h55;
    #1;
    vectors++;
    if (load_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_wb_resolves got=%b exp=0", load_stall);
    end
    vectors++;
    if (read_data_1 !== 32'h55) begin
      miscompares++;
      $display("FAIL sb_wb_data got=%h exp=%h", read_data_1, 32'h55);
    end
    tick();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 5'd9;
    #1;
    vectors++;
    if (load_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_busy_cleared got=%b exp=0", load_stall);
    end
    $display("test_scoreboard: $9=%h stall=%b", read_data_1, load_stall);
    tick();
  endtask

  task automatic test_collision_flush();
    idle();
    write_en = 1'b1; write_addr = 5'd4; write_data = 32'h44;
    busy_set_en = 1'b1; busy_set_addr = 5'd4;
    tick();
    idle();
    busy_set_en = 1'b1; busy_set_addr = 5'd8;
    read_en_1 = 1'b1; read_addr_1 = 5'd4;
    #1;
    vectors++;
    if (load_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_set_wins got=%b exp=1", load_stall);
    end
    tick();
    idle();
    flush = 1'b1; busy_set_en = 1'b1; busy_set_addr = 5'd6;
    tick();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 5'd4;
    read_en_2 = 1'b1; read_addr_2 = 5'd8;
    #1;
    vectors++;
    if (load_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clears got=%b exp=0", load_stall);
    end
    read_en_1 = 1'b0; read_addr_1 = 5'd6;
    read_addr_2 = 5'd6;
    #1;
    vectors++;
    if (load_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_keeps_set got=%b exp=1", load_stall);
    end
    tick();
    idle();
    rst_n = 1'b0;
    write_en = 1'b1; write_addr = 5'd10; write_data = 32'hA5A5A5A5;
    busy_set_en = 1'b1; busy_set_addr = 5'd11;
    tick();
    idle();
    read_en_1 = 1'b1; read_addr_1 = 5'd6;
    read_en_2 = 1'b1; read_addr_2 = 5'd11;
    #1;
    vectors++;
    if (load_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_clears_busy got=%b exp=0", load_stall);
    end
    read_addr_1 = 5'd4; read_addr_2 = 5'd10;
    #1;
    vectors++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_clears_gpr got=%h/%h exp=0/0", read_data_1, read_data_2);
    end
    $display("test_collision_flush: post-reset stall=%b data=%h/%h", load_stall, read_data_1, read_data_2);
    tick();
  endtask

  task automatic test_random(input int n);
    logic [31:0] e1, e2;
    logic        es;
    int          bad;
    for (int k = 0; k < n; k++) begin
      rst_n         = ($urandom_range(0, 59) != 0);
      read_en_1     = ($urandom_range(0, 3) != 0);
      read_addr_1   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      read_en_2     = ($urandom_range(0, 3) != 0);
      read_addr_2   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      write_en      = $urandom_range(0, 1) == 1;
      write_addr    = 5'($urandom_range(0, 7));
      write_data    = $urandom;
      busy_set_en   = ($urandom_range(0, 2) == 0);
      busy_set_addr = 5'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 19) == 0);
`ifdef REGFILE_DEBUG_EN
      debug_addr    = 5'($urandom_range(0, 7));
`endif
      #1;
      e1  = m_read(read_en_1, read_addr_1);
      e2  = m_read(read_en_2, read_addr_2);
      es  = m_stall();
      bad = 0;
      vectors++;
      if (read_data_1 !== e1) begin
        miscompares++; bad++;
        $display("FAIL rand_rd1 k=%0d got=%h exp=%h", k, read_data_1, e1);
      end
      vectors++;
      if (read_data_2 !== e2) begin
        miscompares++; bad++;
        $display("FAIL rand_rd2 k=%0d got=%h exp=%h", k, read_data_2, e2);
      end
      vectors++;
      if (load_stall !== es) begin
        miscompares++; bad++;
        $display("FAIL rand_stall k=%0d got=%b exp=%b", k, load_stall, es);
      end
`ifdef REGFILE_DEBUG_EN
      vectors++;
      if (debug_data !== m_read(1'b1, debug_addr)) begin
        miscompares++; bad++;
        $display("FAIL rand_debug k=%0d got=%h exp=%h", k, debug_data, m_read(1'b1, debug_addr));
      end
`endif
      $display("rand %0d: rst_n=%b we=%b wa=%0d re=%b%b ra=%0d/%0d bs=%b/%0d fl=%b stall=%b errs=%0d",
               k, rst_n, write_en, write_addr, read_en_1, read_en_2, read_addr_1, read_addr_2,
               busy_set_en, busy_set_addr, flush, load_stall, bad);
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_collision_flush();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
